updn_btn_ctrl: RTL and testbench



---
 rtl/updn_btn_ctrl.sv | 235 +++++++++++++++++++++++
 tb/tb_updn_btn_ctrl.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/updn_btn_ctrl.sv
// Button front-end for the up/down counter: synchronize, debounce, edge-detect and
// auto-repeat raw buttons, then issue one-cycle load/Down/Up commands with limit gating.

module updn_btn_dbnc #(
  parameter int unsigned DB_CYCLES = 4
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_btn,
  output logic o_level
);

  localparam int unsigned CW = $clog2(DB_CYCLES);

  logic          r_meta;
  logic          r_sync;
  logic          r_db;
  logic [CW-1:0] r_cnt;

  // Two-flop synchronizer feeding a stable-sample counter; level accepted after DB_CYCLES samples.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
      r_db   <= 1'b0;
      r_cnt  <= '0;
    end else begin
      r_meta <= i_btn;
      r_sync <= r_meta;
      if (r_sync == r_db) begin
        r_cnt <= '0;
      end else if (r_cnt == CW'(DB_CYCLES - 1)) begin
        r_db  <= r_sync;
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + CW'(1);
      end
    end
  end

  assign o_level = r_db;

endmodule


module updn_btn_rpt #(
  parameter int unsigned RPT_DELAY  = 8,
  parameter int unsigned RPT_PERIOD = 4
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_level,
  output logic o_req_c
);

  localparam int unsigned TMAX = (RPT_DELAY > RPT_PERIOD) ? RPT_DELAY : RPT_PERIOD;
  localparam int unsigned TW   = $clog2(TMAX + 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DELAY,
    ST_REPEAT
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [TW-1:0] r_timer;
  logic [TW-1:0] w_timer_nxt;
  logic          r_level_d;
  logic          w_press;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state   <= ST_IDLE;
      r_timer   <= '0;
      r_level_d <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_timer   <= w_timer_nxt;
      r_level_d <= i_level;
    end
  end

  // A dropped debounced level aborts any state at once; otherwise pulse on press, then on timer expiry.
  always_comb begin
    w_state_nxt = r_state;
    w_timer_nxt = r_timer;
    o_req_c     = 1'b0;
    w_press     = i_level & ~r_level_d;
    if (!i_level) begin
      w_state_nxt = ST_IDLE;
      w_timer_nxt = '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_press) begin
            o_req_c     = 1'b1;
            w_state_nxt = ST_DELAY;
            w_timer_nxt = TW'(1);
          end
        end
        ST_DELAY: begin
          if (r_timer == TW'(RPT_DELAY)) begin
            o_req_c     = 1'b1;
            w_state_nxt = ST_REPEAT;
            w_timer_nxt = TW'(1);
          end else begin
            w_timer_nxt = r_timer + TW'(1);
          end
        end
        ST_REPEAT: begin
          if (r_timer == TW'(RPT_PERIOD)) begin
            o_req_c     = 1'b1;
            w_timer_nxt = TW'(1);
          end else begin
            w_timer_nxt = r_timer + TW'(1);
          end
        end
        default: begin
          w_state_nxt = ST_IDLE;
          w_timer_nxt = '0;
        end
      endcase
    end
  end

endmodule


module updn_btn_ctrl #(
  parameter int unsigned WIDTH      = 5,
  parameter int unsigned DB_CYCLES  = 4,
  parameter int unsigned RPT_DELAY  = 8,
  parameter int unsigned RPT_PERIOD = 4
) (
  input  logic             CLK,
  input  logic             rst,
  input  logic             Up_btn,
  input  logic             Dn_btn,
  input  logic             Ld_btn,
  input  logic [WIDTH-1:0] IN_sw,
  input  logic             High,
  input  logic             Low,
  output logic             Up,
  output logic             Down,
  output logic             load,
  output logic [WIDTH-1:0] IN
);

  logic             w_up_level;
  logic             w_dn_level;
  logic             w_ld_level;
  logic             w_up_req_c;
  logic             w_dn_req_c;
  logic             w_ld_req;
  logic             w_up_ok;
  logic             w_dn_ok;
  logic             w_grant_up;
  logic             w_grant_dn;
  logic             w_grant_ld;
  logic             r_ld_d;
  logic             r_up;
  logic             r_down;
  logic             r_load;
  logic [WIDTH-1:0] r_in;

  updn_btn_dbnc #(.DB_CYCLES(DB_CYCLES)) u_dbnc_up (
    .i_clk   (CLK),
    .i_rst   (rst),
    .i_btn   (Up_btn),
    .o_level (w_up_level)
  );

  updn_btn_dbnc #(.DB_CYCLES(DB_CYCLES)) u_dbnc_dn (
    .i_clk   (CLK),
    .i_rst   (rst),
    .i_btn   (Dn_btn),
    .o_level (w_dn_level)
  );

  updn_btn_dbnc #(.DB_CYCLES(DB_CYCLES)) u_dbnc_ld (
    .i_clk   (CLK),
    .i_rst   (rst),
    .i_btn   (Ld_btn),
    .o_level (w_ld_level)
  );

  updn_btn_rpt #(.RPT_DELAY(RPT_DELAY), .RPT_PERIOD(RPT_PERIOD)) u_rpt_up (
    .i_clk   (CLK),
    .i_rst   (rst),
    .i_level (w_up_level),
    .o_req_c (w_up_req_c)
  );

  updn_btn_rpt #(.RPT_DELAY(RPT_DELAY), .RPT_PERIOD(RPT_PERIOD)) u_rpt_dn (
    .i_clk   (CLK),
    .i_rst   (rst),
    .i_level (w_dn_level),
    .o_req_c (w_dn_req_c)
  );

  // Limit gating happens before priority, so a blocked Down never masks a legal Up.
  always_comb begin
    w_ld_req   = w_ld_level & ~r_ld_d;
    w_dn_ok    = w_dn_req_c & ~Low;
    w_up_ok    = w_up_req_c & ~High;
    w_grant_ld = w_ld_req;
    w_grant_dn = w_dn_ok & ~w_ld_req;
    w_grant_up = w_up_ok & ~w_ld_req & ~w_dn_ok;
  end

  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      r_ld_d <= 1'b0;
      r_up   <= 1'b0;
      r_down <= 1'b0;
      r_load <= 1'b0;
      r_in   <= '0;
    end else begin
      r_ld_d <= w_ld_level;
      r_up   <= w_grant_up;
      r_down <= w_grant_dn;
      r_load <= w_grant_ld;
      if (w_grant_ld) begin
        r_in <= IN_sw;
      end
    end
  end

  assign Up   = r_up;
  assign Down = r_down;
  assign load = r_load;
  assign IN   = r_in;

endmodule

// File: tb/tb_updn_btn_ctrl.sv
// Scoreboard bench for updn_btn_ctrl: directed presses push expected pulses,
// a negedge monitor pops and compares them and checks one-hot/limit invariants.

module tb_updn_btn_ctrl;

  localparam logic [2:0] K_UP = 3'b001;
  localparam logic [2:0] K_DN = 3'b010;
  localparam logic [2:0] K_LD = 3'b100;

  typedef struct {
    int unsigned t;
    logic [2:0]  kind;
    logic [4:0]  val;
  } exp_t;

  logic       CLK;
  logic       rst;
  logic       Up_btn;
  logic       Dn_btn;
  logic       Ld_btn;
  logic [4:0] IN_sw;
  logic       High;
  logic       Low;
  logic       Up;
  logic       Down;
  logic       load;
  logic [4:0] IN;

  exp_t        exp_q[$];
  exp_t        e;
  int unsigned cyc;
  int unsigned n_tests;
  int unsigned n_fail;
  int unsigned n_up_seen;
  int unsigned n_dn_seen;
  int unsigned n_ld_seen;
  logic        hi_req;
  logic        lo_req;
  logic        sb_on;
  logic [2:0]  outs;

  updn_btn_ctrl dut (
    .CLK    (CLK),
    .rst    (rst),
    .Up_btn (Up_btn),
    .Dn_btn (Dn_btn),
    .Ld_btn (Ld_btn),
    .IN_sw  (IN_sw),
    .High   (High),
    .Low    (Low),
    .Up     (Up),
    .Down   (Down),
    .load   (load),
    .IN     (IN)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  always @(posedge CLK) begin
    cyc    <= cyc + 1;
    hi_req <= High;
    lo_req <= Low;
  end

  task automatic check(input string name, input int unsigned act, input int unsigned exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push(input int unsigned t, input logic [2:0] k, input logic [4:0] v);
    exp_t x;
    x.t    = t;
    x.kind = k;
    x.val  = v;
    exp_q.push_back(x);
  endtask

  // Monitor: invariants every pulse, scoreboard matching when enabled.
  always @(negedge CLK) begin
    if (!rst) begin
      outs = {load, Down, Up};
      if (Up)   n_up_seen++;
      if (Down) n_dn_seen++;
      if (load) n_ld_seen++;
      if (outs != 3'b000) begin
        n_tests++;
        if (!$onehot(outs) || (Up && hi_req) || (Down && lo_req)) begin
          n_fail++;
          $display("FAIL invariant: cyc %0d outs=%b High=%b Low=%b, required one-hot within limits",
                   cyc, outs, hi_req, lo_req);
        end
      end
      if (sb_on) begin
        while (exp_q.size() != 0 && exp_q[0].t < cyc) begin
          n_tests++;
          n_fail++;
          $display("FAIL missing_pulse: got nothing at cyc %0d, expected kind %b", exp_q[0].t, exp_q[0].kind);
          exp_q.delete(0);
        end
        if (outs != 3'b000) begin
          n_tests++;
          if (exp_q.size() != 0 && exp_q[0].t == cyc) begin
            e = exp_q.pop_front();
            if (e.kind != outs || (outs[2] && IN != e.val)) begin
              n_fail++;
              $display("FAIL pulse: cyc %0d got outs=%b IN=%0d expected outs=%b IN=%0d",
                       cyc, outs, IN, e.kind, e.val);
            end
          end else begin
            n_fail++;
            $display("FAIL unexpected_pulse: cyc %0d got outs=%b expected none", cyc, outs);
          end
        end
      end
    end
  end

  int unsigned t0;
  int unsigned base;

  initial begin
    cyc = 0; n_tests = 0; n_fail = 0;
    n_up_seen = 0; n_dn_seen = 0; n_ld_seen = 0;
    hi_req = 1'b0; lo_req = 1'b0; sb_on = 1'b1;
    rst = 1'b1; Up_btn = 1'b0; Dn_btn = 1'b0; Ld_btn = 1'b0;
    IN_sw = 5'd0; High = 1'b0; Low = 1'b0;

    // Reset state
    repeat (3) @(negedge CLK);
    check("reset_cmds", {29'd0, load, Down, Up}, 0);
    check("reset_IN", IN, 0);
    rst = 1'b0;
    repeat (5) @(negedge CLK);

    // Glitch of 3 samples is filtered
    base = n_up_seen;
    Up_btn = 1'b1;
    repeat (3) @(negedge CLK);
    Up_btn = 1'b0;
    repeat (15) @(negedge CLK);
    check("glitch_no_up", n_up_seen - base, 0);

    // Held Up: pulses at P, P+8, P+12
    base = n_up_seen;
    t0 = cyc;
    Up_btn = 1'b1;
    push(t0 + 7, K_UP, 5'd0);
    push(t0 + 15, K_UP, 5'd0);
    push(t0 + 19, K_UP, 5'd0);
    repeat (14) @(negedge CLK);
    Up_btn = 1'b0;
    repeat (15) @(negedge CLK);
    check("hold_up_count", n_up_seen - base, 3);

    // Reset while held: outputs drop at once, new press after release
    t0 = cyc;
    Up_btn = 1'b1;
    push(t0 + 7, K_UP, 5'd0);
    repeat (7) @(negedge CLK);
    check("pre_reset_up", Up, 1);
    #2 rst = 1'b1;
    #1 check("async_reset_up", Up, 0);
    repeat (2) @(negedge CLK);
    t0 = cyc;
    rst = 1'b0;
    push(t0 + 7, K_UP, 5'd0);
    repeat (8) @(negedge CLK);
    Up_btn = 1'b0;
    repeat (15) @(negedge CLK);

    // Load held 40 cycles: one pulse, value held
    IN_sw = 5'd9;
    @(negedge CLK);
    base = n_ld_seen;
    t0 = cyc;
    Ld_btn = 1'b1;
    push(t0 + 7, K_LD, 5'd9);
    repeat (20) @(negedge CLK);
    IN_sw = 5'd5;
    repeat (20) @(negedge CLK);
    Ld_btn = 1'b0;
    repeat (15) @(negedge CLK);
    check("load_count", n_ld_seen - base, 1);
    check("load_IN_held", IN, 9);

    // Priority: Down beats Up; load takes a Down repeat slot
    base = n_up_seen;
    t0 = cyc;
    Up_btn = 1'b1;
    Dn_btn = 1'b1;
    push(t0 + 7, K_DN, 5'd0);
    push(t0 + 15, K_DN, 5'd0);
    push(t0 + 19, K_DN, 5'd0);
    push(t0 + 23, K_LD, 5'd5);
    push(t0 + 27, K_DN, 5'd0);
    repeat (16) @(negedge CLK);
    Ld_btn = 1'b1;
    repeat (6) @(negedge CLK);
    Up_btn = 1'b0;
    Dn_btn = 1'b0;
    Ld_btn = 1'b0;
    repeat (15) @(negedge CLK);
    check("prio_no_up", n_up_seen - base, 0);
    check("prio_load_IN", IN, 5);

    // High limit blocks Up until it drops
    High = 1'b1;
    @(negedge CLK);
    base = n_up_seen;
    t0 = cyc;
    Up_btn = 1'b1;
    push(t0 + 31, K_UP, 5'd0);
    push(t0 + 35, K_UP, 5'd0);
    repeat (28) @(negedge CLK);
    check("high_block_up", n_up_seen - base, 0);
    High = 1'b0;
    repeat (4) @(negedge CLK);
    Up_btn = 1'b0;
    repeat (15) @(negedge CLK);
    check("high_resume_up", n_up_seen - base, 2);

    // Low limit blocks Down until it drops
    Low = 1'b1;
    @(negedge CLK);
    base = n_dn_seen;
    t0 = cyc;
    Dn_btn = 1'b1;
    push(t0 + 31, K_DN, 5'd0);
    push(t0 + 35, K_DN, 5'd0);
    repeat (28) @(negedge CLK);
    check("low_block_dn", n_dn_seen - base, 0);
    Low = 1'b0;
    repeat (4) @(negedge CLK);
    Dn_btn = 1'b0;
    repeat (15) @(negedge CLK);
    check("low_resume_dn", n_dn_seen - base, 2);
    check("sb_queue_empty", exp_q.size(), 0);

    // Random stimulus: invariants only
    sb_on = 1'b0;
    for (int i = 0; i < 10000; i++) begin
      @(negedge CLK);
      if ($urandom_range(7) == 0) Up_btn = ~Up_btn;
      if ($urandom_range(7) == 0) Dn_btn = ~Dn_btn;
      if ($urandom_range(15) == 0) Ld_btn = ~Ld_btn;
      if ($urandom_range(15) == 0) High = ~High;
      if ($urandom_range(15) == 0) Low = ~Low;
      IN_sw = 5'($urandom_range(31));
    end
    Up_btn = 1'b0;
    Dn_btn = 1'b0;
    Ld_btn = 1'b0;
    High = 1'b0;
    Low = 1'b0;
    repeat (20) @(negedge CLK);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
